// File: rtl/mips_result_serializer_if.sv
// +-----------------------------------------------------------------------+
// | mips_result_serializer_if : record capture bus and beat stream bus    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

interface mips_result_serializer_if;
  logic        in_valid;
  logic        in_fail;
  logic [15:0] in_reg0;
  logic [15:0] in_reg1;
  logic [15:0] in_reg2;
  logic [15:0] in_reg3;
  logic [15:0] in_reg4;
  logic [15:0] in_reg5;
  logic        dout_valid;
  logic        dout_ready;
  logic [15:0] dout_data;
  logic        dout_last;

  modport master (
    output in_valid, in_fail, in_reg0, in_reg1, in_reg2, in_reg3, in_reg4, in_reg5,
    output dout_ready,
    input  dout_valid, dout_data, dout_last
  );

  modport slave (
    input  in_valid, in_fail, in_reg0, in_reg1, in_reg2, in_reg3, in_reg4, in_reg5,
    input  dout_ready,
    output dout_valid, dout_data, dout_last
  );
endinterface

`default_nettype wire

// File: rtl/mips_result_serializer.sv
// +-----------------------------------------------------------------------+
// | mips_result_serializer : buffers core result records in a FIFO and    |
// | streams each one as a 7-beat packet (header + six registers).         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module mips_result_serializer #(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  mips_result_serializer_if.slave      bus,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int               PTR_W     = $clog2(DEPTH);
  localparam int               LVL_W     = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] DEPTH_L   = LVL_W'(DEPTH);
  localparam logic [2:0]       LAST_BEAT = 3'd6;

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  typedef struct packed {
    logic             fail;
    logic [SEQ_W-1:0] seq;
    logic [5:0][15:0] regs;
  } rec_t;

  rec_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_next;
  logic [LVL_W-1:0] level_q, level_d;
  logic [SEQ_W-1:0] seq_q;
  logic             overflow_q;
  state_t           state_q, state_d;
  logic [2:0]       beat_q, beat_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [15:0]      data_q, data_d;
  rec_t             in_rec, head_rec, next_rec;
  logic             hs, pop, push;

  function automatic logic [15:0] beat_word(input rec_t r, input logic [2:0] b);
    logic [15:0] w;
    w = '0;
    if (b == 3'd0) begin
      w[15]        = r.fail;
      w[SEQ_W-1:0] = r.seq;
    end else begin
      w = r.regs[b - 3'd1];
    end
    return w;
  endfunction

  always_comb begin
    in_rec      = '0;
    in_rec.fail = bus.in_fail;
    in_rec.seq  = seq_q;
    in_rec.regs = {bus.in_reg5, bus.in_reg4, bus.in_reg3,
                   bus.in_reg2, bus.in_reg1, bus.in_reg0};
  end

  assign hs       = valid_q & bus.dout_ready;
  assign pop      = hs & last_q;
  // A full FIFO still accepts a record if its head leaves on this very edge.
  assign push     = bus.in_valid & ((level_q != DEPTH_L) | pop);
  assign rd_next  = rd_ptr_q + PTR_W'(1);
  assign head_rec = mem_q[rd_ptr_q];
  // With only the departing record stored, the next one is still on the input bus.
  assign next_rec = (level_q == LVL_W'(1)) ? in_rec : mem_q[rd_next];

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          state_d = SEND;
          beat_d  = 3'd0;
          valid_d = 1'b1;
          last_d  = 1'b0;
          data_d  = beat_word(head_rec, 3'd0);
        end
      end
      SEND: begin
        if (hs) begin
          if (beat_q == LAST_BEAT) begin
            beat_d = 3'd0;
            last_d = 1'b0;
            if (level_d != '0) begin
              valid_d = 1'b1;
              data_d  = beat_word(next_rec, 3'd0);
            end else begin
              state_d = IDLE;
              valid_d = 1'b0;
              data_d  = '0;
            end
          end else begin
            beat_d = beat_q + 3'd1;
            last_d = ((beat_q + 3'd1) == LAST_BEAT);
            data_d = beat_word(head_rec, beat_q + 3'd1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= 3'd0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
      level_q    <= '0;
      seq_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      level_q <= level_d;
      if (bus.in_valid) seq_q <= seq_q + SEQ_W'(1);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) rd_ptr_q <= rd_next;
      if (bus.in_valid && !push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= in_rec;
  end

  assign bus.dout_valid = valid_q;
  assign bus.dout_data  = data_q;
  assign bus.dout_last  = last_q;
  assign overflow       = overflow_q;
  assign level          = level_q;

endmodule

`default_nettype wire
